// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Frame: start, 8 data bits LSB-first, even parity, stop.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    function automatic int ticks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset high so reset release never looks like a start edge.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o      = sync_q;
    assign fall_edge_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit 3-sample majority vote, 8E1 framing,
// byte presented with a one-cycle strobe plus held error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int TICKS = ticks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = TICKS / 2;
    localparam int TW    = $clog2(TICKS);

    localparam logic [TW-1:0] T_LAST = TW'(TICKS - 1);
    localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
    localparam logic [TW-1:0] T_S1   = TW'(HALF);
    localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);

    logic rx_s;
    logic fall_edge;

    uart_rx_sync u_sync (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_i        (rx_in),
        .rx_s_o      (rx_s),
        .fall_edge_o (fall_edge)
    );

    rx_state_t            state_q;
    logic [TW-1:0]        timer_q;
    logic [TW-1:0]        timer_d;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 valid_q;
    logic                 busy_q;

    logic decide;
    logic bit_v;

    // Third vote is the live sample at the decision tick.
    assign bit_v = (samp_q[0] & samp_q[1])
                 | (samp_q[0] & rx_s)
                 | (samp_q[1] & rx_s);

    assign decide  = (timer_q == T_DEC);
    assign timer_d = (timer_q == T_LAST) ? '0 : timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            samp_q    <= 2'b11;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (timer_q == T_S0) samp_q[0] <= rx_s;
            if (timer_q == T_S1) samp_q[1] <= rx_s;

            unique case (state_q)
                IDLE: begin
                    if (fall_edge) begin
                        state_q <= START;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    timer_q <= timer_d;
                    if (decide) begin
                        if (bit_v) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end
                    end
                end
                DATA: begin
                    timer_q <= timer_d;
                    if (decide) begin
                        shift_q   <= {bit_v, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= PARITY;
                    end
                end
                PARITY: begin
                    timer_q <= timer_d;
                    if (decide) begin
                        parity_q <= bit_v;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    timer_q <= timer_d;
                    if (decide) begin
                        data_q  <= shift_q;
                        perr_q  <= (^shift_q) != parity_q;
                        ferr_q  <= ~bit_v;
                        valid_q <= 1'b1;
                        if (bit_v) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a bit-accurate line model.
// A negedge monitor logs every strobe; scenario tasks check the log.
module tb_uart_receiver;

    localparam int T    = 50_000_000 / 115200;
    localparam int HALF = T / 2;

    logic       clk;
    logic       reset;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] q_data[$];
    logic       q_perr[$];
    logic       q_ferr[$];
    int         q_cyc[$];
    int         bad_chg = 0;
    logic [7:0] prev_data;
    logic       prev_perr;
    logic       prev_ferr;

    uart_receiver dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            q_data.push_back(rx_data);
            q_perr.push_back(rx_parity_err);
            q_ferr.push_back(rx_frame_err);
            q_cyc.push_back(cyc);
        end else if (!reset) begin
            if (rx_data !== prev_data || rx_parity_err !== prev_perr
                || rx_frame_err !== prev_ferr)
                bad_chg++;
        end
        prev_data = rx_data;
        prev_perr = rx_parity_err;
        prev_ferr = rx_frame_err;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (T) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic check_last(input string nm, input int n_exp,
                              input logic [7:0] d, input logic pe,
                              input logic fe);
        checks++;
        if (q_data.size() != n_exp) begin
            errors++;
            $display("FAIL %s strobes: got %0d want %0d", nm, q_data.size(), n_exp);
        end else begin
            checks++;
            if (q_data[n_exp-1] !== d || q_perr[n_exp-1] !== pe
                || q_ferr[n_exp-1] !== fe) begin
                errors++;
                $display("FAIL %s frame: got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                         nm, q_data[n_exp-1], q_perr[n_exp-1], q_ferr[n_exp-1],
                         d, pe, fe);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_in = 1'b1;
        idle(3);
        checks++;
        if ({rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_vals: got d=%h v=%b pe=%b fe=%b b=%b want all 0",
                     rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy);
        end
        reset = 1'b0;
        idle(10);
        checks++;
        if (rx_busy !== 1'b0 || q_data.size() != 0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b strobes=%0d want 0/0",
                     rx_busy, q_data.size());
        end
    endtask

    task automatic test_basic;
        int n0;
        int c0;
        int lat;
        n0 = q_data.size();
        c0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        check_last("basic_A5", n0 + 1, 8'hA5, 1'b0, 1'b0);
        if (q_cyc.size() > n0) begin
            lat = q_cyc[n0] - c0;
            checks++;
            if (lat < 10*T + HALF + 1 || lat > 10*T + HALF + 6) begin
                errors++;
                $display("FAIL latency: got %0d want %0d..%0d",
                         lat, 10*T + HALF + 1, 10*T + HALF + 6);
            end
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b want 0", rx_busy);
        end
    endtask

    task automatic test_parity;
        int n0;
        n0 = q_data.size();
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        check_last("parity_3C", n0 + 1, 8'h3C, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        check_last("parity_07", n0 + 2, 8'h07, 1'b0, 1'b0);
    endtask

    task automatic test_frame_err;
        int n0;
        n0 = q_data.size();
        send_frame(8'h81, 1'b0, 1'b0);
        check_last("frame_81", n0 + 1, 8'h81, 1'b0, 1'b1);
        idle(2*T);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b want 1", rx_busy);
        end
        rx_in = 1'b1;
        idle(10);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL break_release: got %b want 0", rx_busy);
        end
        send_frame(8'h55, 1'b0, 1'b1);
        idle(20);
        check_last("after_break_55", n0 + 2, 8'h55, 1'b0, 1'b0);
    endtask

    task automatic test_both_err;
        int n0;
        n0 = q_data.size();
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(T);
        rx_in = 1'b1;
        idle(20);
        check_last("both_err", n0 + 1, 8'h3C, 1'b1, 1'b1);
    endtask

    task automatic test_glitch;
        int n0;
        n0 = q_data.size();
        rx_in = 1'b0;
        idle(100);
        rx_in = 1'b1;
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_seen: got busy=%b want 1", rx_busy);
        end
        idle(HALF + 6 - 100);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy: got %b want 0", rx_busy);
        end
        idle(2*T);
        checks++;
        if (q_data.size() != n0) begin
            errors++;
            $display("FAIL glitch_strobe: got %0d want %0d", q_data.size(), n0);
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        logic [7:0] d;
        d = 8'hF0;
        n0 = q_data.size();
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(d[i]);
        reset = 1'b1;
        rx_in = 1'b1;
        idle(2);
        checks++;
        if ({rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_vals: got d=%h v=%b pe=%b fe=%b b=%b want all 0",
                     rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy);
        end
        reset = 1'b0;
        idle(2*T);
        checks++;
        if (q_data.size() != n0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: got strobes=%0d busy=%b want %0d/0",
                     q_data.size(), rx_busy, n0);
        end
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(20);
        check_last("after_reset_0F", n0 + 1, 8'h0F, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int n0;
        logic [7:0] exp_d[3];
        exp_d[0] = 8'h00;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h5A;
        n0 = q_data.size();
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], ^exp_d[i], 1'b1);
        idle(20);
        checks++;
        if (q_data.size() != n0 + 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", q_data.size() - n0, 3);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_data[n0+i] !== exp_d[i] || q_perr[n0+i] !== 1'b0
                    || q_ferr[n0+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_%0d: got d=%h pe=%b fe=%b want d=%h pe=0 fe=0",
                             i, q_data[n0+i], q_perr[n0+i], q_ferr[n0+i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_hold;
        checks++;
        if (bad_chg != 0) begin
            errors++;
            $display("FAIL hold_outputs: got %0d changes without strobe want 0",
                     bad_chg);
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_in = 1'b1;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_both_err();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        test_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
